mem_bus_bridge: RTL

- Off-chip memory-side partner of the CPU top level. It consumes the CPU's 12-bit multiplexed output bus {read_write, write_commit, addr_data[9:0]} and produces the 12-bit mem_result bus the CPU samples.
- Contains a DEPTH x 12 word store serving instruction fetch, loads, and two-beat stores.
- Has a host preload port with a valid/ready handshake so program images can be written while the CPU is held in reset.

---
 rtl/mem_bus_bridge_if.sv | 22 ++
 rtl/mem_bus_bridge.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge_if.sv
// CPU multiplexed bus, read-data return and host preload handshake for mem_bus_bridge.
// master = CPU/host side, slave = bridge side.
interface mem_bus_bridge_if;
   logic [11:0] bus_in;
   logic [11:0] bus_out;
   logic        load_valid;
   logic        load_ready;
   logic [9:0]  load_addr;
   logic [11:0] load_data;
   logic        wr_done;
   logic        err;

   modport master (
      output bus_in, load_valid, load_addr, load_data,
      input  bus_out, load_ready, wr_done, err
   );

   modport slave (
      input  bus_in, load_valid, load_addr, load_data,
      output bus_out, load_ready, wr_done, err
   );
endinterface

// File: rtl/mem_bus_bridge.sv
// CPU-side word store: reads return 1 cycle after the beat, stores take an address beat then a commit beat.
// Preload backpressure: load_ready drops for the one cycle after a commit, while the committed word drains.
module mem_bus_bridge #(
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_bridge_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, WR_PEND} state_t;

   typedef struct packed {
      logic       rw;
      logic       commit;
      logic [9:0] ad;
   } beat_t;

   function automatic logic in_range(input logic [9:0] a);
      return {1'b0, a} < 11'(DEPTH);
   endfunction

   beat_t         beat;
   state_t        state_q, state_d;
   logic [9:0]    wa_q, wa_d;
   logic [11:0]   bus_out_q;
   logic          wr_done_q;
   logic          err_q;
   logic          ready_q, ready_d;
   logic          rd_en;
   logic          commit;
   logic          proto_err;
   logic          err_set;
   logic          load_fire;
   logic          load_ok;
   logic          commit_ok;

   // Committed store word, written to the array on the following edge.
   logic          sb_vld_q;
   logic [AW-1:0] sb_idx_q;
   logic [5:0]    sb_dat_q;

   logic [11:0]   mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_idx;
   logic [11:0]   mem_dat;
   logic [11:0]   rd_dat;

   assign beat = beat_t'(bus.bus_in);

   always_comb begin
      state_d   = state_q;
      wa_d      = wa_q;
      rd_en     = 1'b0;
      commit    = 1'b0;
      proto_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (!beat.rw) begin
               rd_en = 1'b1;
            end else if (!beat.commit) begin
               wa_d    = beat.ad;
               state_d = WR_PEND;
            end else begin
               proto_err = 1'b1;
            end
         end
         WR_PEND: begin
            if (!beat.rw) begin
               rd_en   = 1'b1;
               state_d = IDLE;
            end else if (beat.commit) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else begin
               wa_d = beat.ad;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_fire = rst && bus.load_valid && ready_q;
   assign load_ok   = in_range(bus.load_addr);
   assign commit_ok = in_range(wa_q);
   assign err_set   = proto_err || (commit && !commit_ok) || (load_fire && !load_ok);
   assign ready_d   = !commit;

   // Single write port: the drained store and an accepted preload never coincide
   // because load_ready is low whenever the store buffer is full.
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = bus.load_addr[AW-1:0];
      mem_dat = bus.load_data;
      if (sb_vld_q) begin
         mem_we  = 1'b1;
         mem_idx = sb_idx_q;
         mem_dat = {6'b0, sb_dat_q};
      end else if (load_fire && load_ok) begin
         mem_we = 1'b1;
      end
   end

   // The store buffer is forwarded so a read right after a commit sees the new word.
   always_comb begin
      rd_dat = 12'h000;
      if (in_range(beat.ad)) begin
         if (sb_vld_q && sb_idx_q == beat.ad[AW-1:0]) begin
            rd_dat = {6'b0, sb_dat_q};
         end else begin
            rd_dat = mem[beat.ad[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         sb_idx_q <= wa_q[AW-1:0];
         sb_dat_q <= beat.ad[5:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         wa_q      <= '0;
         bus_out_q <= '0;
         wr_done_q <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         sb_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wa_q      <= wa_d;
         if (rd_en) begin
            bus_out_q <= rd_dat;
         end
         wr_done_q <= commit;
         if (err_set) begin
            err_q <= 1'b1;
         end
         ready_q   <= ready_d;
         sb_vld_q  <= commit && commit_ok;
      end
   end

   assign bus.bus_out    = bus_out_q;
   assign bus.wr_done    = wr_done_q;
   assign bus.err        = err_q;
   assign bus.load_ready = ready_q;
endmodule
